// File: rtl/game_judge.sv
// Round referee: ends a round when Tom holds Jerry for CATCH_FRAMES consecutive
// frames (gameover=01) or when the seconds countdown expires (gameover=10).
module game_judge #(
    parameter int CLK_HZ       = 65_000_000,
    parameter int GAME_SECONDS = 60,
    parameter int SPRITE_W     = 64,
    parameter int SPRITE_H     = 64,
    parameter int CATCH_FRAMES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [11:0] tom_x,
    input  logic [11:0] tom_y,
    input  logic [11:0] jerry_x,
    input  logic [11:0] jerry_y,
    output logic [1:0]  gameover,
    output logic        running,
    output logic [7:0]  seconds_left
);

    localparam int              PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [7:0]      SECS      = 8'(GAME_SECONDS);
    localparam logic [3:0]      CATCH_N   = 4'(CATCH_FRAMES);
    localparam logic [12:0]     W13       = 13'(SPRITE_W);
    localparam logic [12:0]     H13       = 13'(SPRITE_H);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    gameover_q, gameover_d;
    logic          running_q, running_d;
    logic [7:0]    seconds_left_q, seconds_left_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    catch_q, catch_d;

    logic [12:0]   tx, ty, jx, jy;
    logic          overlap;
    logic [3:0]    catch_inc;
    logic          presc_wrap;
    logic          catch_evt;
    logic          timeout_evt;

    // 13-bit operands keep corner+size from wrapping near the 4095 edge.
    always_comb begin
        tx = {1'b0, tom_x};
        ty = {1'b0, tom_y};
        jx = {1'b0, jerry_x};
        jy = {1'b0, jerry_y};
        overlap = (tx < jx + W13) && (jx < tx + W13) &&
                  (ty < jy + H13) && (jy < ty + H13);
    end

    always_comb begin
        catch_inc   = (catch_q == 4'hF) ? 4'hF : catch_q + 4'd1;
        presc_wrap  = (presc_q == PRESC_MAX);
        catch_evt   = frame_tick && overlap && (catch_inc == CATCH_N);
        timeout_evt = presc_wrap && (seconds_left_q == 8'd1);
    end

    always_comb begin
        state_d        = state_q;
        gameover_d     = gameover_q;
        running_d      = running_q;
        seconds_left_d = seconds_left_q;
        presc_d        = presc_q;
        catch_d        = catch_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d        = S_RUN;
                    running_d      = 1'b1;
                    seconds_left_d = SECS;
                    presc_d        = '0;
                    catch_d        = 4'd0;
                end
            end
            S_RUN: begin
                if (presc_wrap) begin
                    presc_d        = '0;
                    seconds_left_d = seconds_left_q - 8'd1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                if (frame_tick) begin
                    catch_d = overlap ? catch_inc : 4'd0;
                end
                // A catch outranks a timeout landing on the same edge.
                if (catch_evt) begin
                    state_d    = S_DONE;
                    gameover_d = 2'b01;
                    running_d  = 1'b0;
                end else if (timeout_evt) begin
                    state_d    = S_DONE;
                    gameover_d = 2'b10;
                    running_d  = 1'b0;
                end
            end
            S_DONE: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (reset) begin
            state_d        = S_IDLE;
            gameover_d     = 2'b00;
            running_d      = 1'b0;
            seconds_left_d = SECS;
            presc_d        = '0;
            catch_d        = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            gameover_q     <= 2'b00;
            running_q      <= 1'b0;
            seconds_left_q <= SECS;
            presc_q        <= '0;
            catch_q        <= 4'd0;
        end else begin
            state_q        <= state_d;
            gameover_q     <= gameover_d;
            running_q      <= running_d;
            seconds_left_q <= seconds_left_d;
            presc_q        <= presc_d;
            catch_q        <= catch_d;
        end
    end

    assign gameover     = gameover_q;
    assign running      = running_q;
    assign seconds_left = seconds_left_q;

endmodule

// File: tb/tb_game_judge.sv
// Directed bench for game_judge with a 10-cycle second and a 3-second round.
module tb_game_judge;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        reset;
    logic        frame_tick;
    logic [11:0] tom_x, tom_y, jerry_x, jerry_y;
    logic [1:0]  gameover;
    logic        running;
    logic [7:0]  seconds_left;

    int errors = 0;
    int checks = 0;

    game_judge #(
        .CLK_HZ      (10),
        .GAME_SECONDS(3),
        .SPRITE_W    (64),
        .SPRITE_H    (64),
        .CATCH_FRAMES(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .tom_x       (tom_x),
        .tom_y       (tom_y),
        .jerry_x     (jerry_x),
        .jerry_y     (jerry_y),
        .gameover    (gameover),
        .running     (running),
        .seconds_left(seconds_left)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] go, input logic run, input logic [7:0] sec);
        chk({tag, ".gameover"}, {6'd0, gameover}, {6'd0, go});
        chk({tag, ".running"}, {7'd0, running}, {7'd0, run});
        chk({tag, ".seconds"}, seconds_left, sec);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic set_pos(input int tx, input int ty, input int jx, input int jy);
        tom_x   = 12'(tx);
        tom_y   = 12'(ty);
        jerry_x = 12'(jx);
        jerry_y = 12'(jy);
    endtask

    initial begin
        // Reset with random inputs applied.
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start      = 1'($urandom_range(0, 1));
            reset      = 1'($urandom_range(0, 1));
            frame_tick = 1'($urandom_range(0, 1));
            set_pos($urandom_range(0, 4095), $urandom_range(0, 4095),
                    $urandom_range(0, 4095), $urandom_range(0, 4095));
            step();
        end
        chk_out("reset", 2'b00, 1'b0, 8'd3);
        rst = 1'b1;
        start = 1'b0;
        reset = 1'b0;
        frame_tick = 1'b0;

        // Ticks with overlap in IDLE are ignored.
        set_pos(100, 100, 150, 120);
        pulse_tick();
        pulse_tick();
        pulse_tick();
        chk_out("idle_ticks", 2'b00, 1'b0, 8'd3);

        // Catch after three consecutive overlapping frames.
        pulse_start();
        chk_out("catch_entry", 2'b00, 1'b1, 8'd3);
        pulse_tick();
        pulse_tick();
        chk_out("catch_tick2", 2'b00, 1'b1, 8'd3);
        pulse_tick();
        chk_out("catch_tick3", 2'b01, 1'b0, 8'd3);
        repeat (15) step();
        chk_out("catch_hold", 2'b01, 1'b0, 8'd3);
        pulse_start();
        chk_out("done_start_ignored", 2'b01, 1'b0, 8'd3);
        pulse_reset();
        chk_out("reset_in_done", 2'b00, 1'b0, 8'd3);

        // Non-consecutive overlap restarts the count; edge touch is not overlap.
        pulse_start();
        pulse_tick();
        pulse_tick();
        set_pos(100, 100, 164, 100);
        pulse_tick();
        chk_out("nc_touch", 2'b00, 1'b1, 8'd3);
        set_pos(100, 100, 150, 120);
        pulse_tick();
        pulse_tick();
        chk_out("nc_two_more", 2'b00, 1'b1, 8'd3);
        pulse_tick();
        chk_out("nc_third", 2'b01, 1'b0, 8'd3);
        pulse_reset();

        // Reset mid-RUN clears seconds and the catch counter.
        pulse_start();
        pulse_tick();
        pulse_tick();
        repeat (9) step();
        chk_out("mid_run_sec2", 2'b00, 1'b1, 8'd2);
        pulse_reset();
        chk_out("reset_mid_run", 2'b00, 1'b0, 8'd3);
        start = 1'b1;
        reset = 1'b1;
        step();
        start = 1'b0;
        reset = 1'b0;
        chk_out("start_with_reset", 2'b00, 1'b0, 8'd3);
        pulse_start();
        pulse_tick();
        pulse_tick();
        chk_out("counter_cleared", 2'b00, 1'b1, 8'd3);
        pulse_reset();

        // Timeout: seconds step 3->2->1->0 every 10 cycles.
        set_pos(0, 0, 1000, 1000);
        pulse_start();
        for (int k = 1; k <= 3; k++) begin
            repeat (9) step();
            chk_out($sformatf("to_pre%0d", k), 2'b00, 1'b1, 8'(4 - k));
            step();
            if (k == 3) chk_out("to_zero", 2'b10, 1'b0, 8'd0);
            else        chk_out($sformatf("to_dec%0d", k), 2'b00, 1'b1, 8'(3 - k));
        end
        repeat (5) step();
        chk_out("to_hold", 2'b10, 1'b0, 8'd0);
        pulse_reset();
        chk_out("to_reset", 2'b00, 1'b0, 8'd3);

        // Catch on the same edge as the final wrap: Tom wins, seconds reach 0.
        set_pos(100, 100, 150, 120);
        pulse_start();
        repeat (27) step();
        pulse_tick();
        pulse_tick();
        chk_out("sim_pre", 2'b00, 1'b1, 8'd1);
        pulse_tick();
        chk_out("sim_both", 2'b01, 1'b0, 8'd0);
        pulse_reset();

        // Near-max coordinates; a tick coinciding with start does not count.
        set_pos(4095, 4095, 4050, 4050);
        start = 1'b1;
        frame_tick = 1'b1;
        step();
        start = 1'b0;
        frame_tick = 1'b0;
        pulse_tick();
        pulse_tick();
        chk_out("max_two", 2'b00, 1'b1, 8'd3);
        pulse_tick();
        chk_out("max_catch", 2'b01, 1'b0, 8'd3);
        pulse_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/game_judge.md
# game_judge

Decides how and when a round ends. Sits directly upstream of the game-over latch and drives its `gameover[1:0]` input. Each frame it checks Tom/Jerry sprite overlap, which must persist for a set number of frames. It also runs a round countdown in seconds. The result is a registered outcome code: 2'b01 means Tom caught Jerry, 2'b10 means time ran out and Jerry wins.

## Interface
Parameters:
- `CLK_HZ`, 65_000_000: `clk` frequency; sets the 1 s prescaler.
- `GAME_SECONDS`, 60: round length in seconds (1..255).
- `SPRITE_W`, 64: collision box width in pixels (both sprites).
- `SPRITE_H`, 64: collision box height in pixels.
- `CATCH_FRAMES`, 3: consecutive overlapping frames required to register a catch (1..15).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: single-cycle pulse that begins a round.
- `reset` in 1: game restart request, level; the same signal that feeds the game-over latch.
- `frame_tick` in 1: single-cycle pulse, once per video frame (end of vsync).
- `tom_x`, `tom_y` in 12 each: Tom sprite top-left corner.
- `jerry_x`, `jerry_y` in 12 each: Jerry sprite top-left corner.
- `gameover` out 2: 00 = no result, 01 = Tom wins, 10 = Jerry wins; 11 is never driven.
- `running` out 1: high while a round is in progress.
- `seconds_left` out 8: remaining round time, for the HUD.

## Operation
- State machine with three states:
  - IDLE: `running`=0, `gameover`=00, `seconds_left`=GAME_SECONDS.
  - RUN: `running`=1.
  - DONE: `running`=0, `gameover` held.
- IDLE -> RUN on `start`=1 with `reset`=0. On entry: prescaler=0, `seconds_left`=GAME_SECONDS, catch counter=0.
- Overlap test is combinational, with operands widened to 13 bits so sums cannot wrap:
  - (tom_x < jerry_x+SPRITE_W) and (jerry_x < tom_x+SPRITE_W)
  - and (tom_y < jerry_y+SPRITE_H) and (jerry_y < tom_y+SPRITE_H).
- Catch counter, 4 bits, updated in RUN only, on `frame_tick` only:
  - overlap -> counter+1, saturating at 15;
  - no overlap -> counter=0.
- Catch event: the counter update reaches CATCH_FRAMES. RUN -> DONE with `gameover`=01.
- Prescaler counts `clk` cycles 0..CLK_HZ-1 in RUN.
  - At wrap, `seconds_left` decrements.
  - Timeout event: decrement from 1 to 0. RUN -> DONE with `gameover`=10.
- Both events in the same cycle: Tom wins (`gameover`=01) and `seconds_left` still updates to 0.
- DONE is held until `reset`=1. `start` in DONE is ignored.
- `reset`=1 in any state forces, on the next edge: IDLE, `gameover`=00, counters cleared, `seconds_left`=GAME_SECONDS. It overrides `start` and any event in the same cycle.
- `frame_tick` and positions are ignored outside RUN.
- The `start`/RUN interaction with `frame_tick` is defined by the single-cycle entry rule: a tick coinciding with `start` is not counted.

## Timing
- `rst`=0 at a rising edge, on the next edge:
  - state=IDLE, `gameover`=00, `running`=0;
  - `seconds_left`=GAME_SECONDS, prescaler=0, catch counter=0.
- All outputs are registered; no combinational path from inputs to outputs.
- `start` sampled at edge N: `running`=1 after edge N.
- Catch: the `frame_tick` that completes CATCH_FRAMES overlapping frames is sampled at edge N. After edge N, `gameover`=01 and `running`=0.
- Timeout: first decrement occurs CLK_HZ cycles after RUN entry. `gameover`=10 appears on the same edge where `seconds_left` becomes 0, i.e. GAME_SECONDS*CLK_HZ cycles after RUN entry.
- The downstream latch therefore sees `gameover` exactly one cycle after the decisive input.
- `gameover` is stable and nonzero for the whole DONE state.

## Test plan
Use CLK_HZ=10, GAME_SECONDS=3, CATCH_FRAMES=3, SPRITE_W=SPRITE_H=64.
- Reset: hold `rst`=0 for 2 cycles with random inputs -> `gameover`=00, `running`=0, `seconds_left`=3.
- Catch:
  - Setup: `start`; tom=(100,100), jerry=(150,120); 3 `frame_tick`s.
  - Required: `gameover`=01 one cycle after the 3rd tick; `running`=0; `seconds_left` frozen.
- Non-consecutive overlap: overlap, overlap, then jerry=(164,100) (edge-touching, so no overlap), then overlap -> `gameover` stays 00. A 3rd consecutive overlap afterwards -> 01.
- Timeout:
  - Setup: `start`; no overlap.
  - Required: `seconds_left` steps 3->2->1->0 at 10-cycle intervals; `gameover`=10 on the edge it hits 0.
- Simultaneous: align the 3rd overlapping `frame_tick` with the final prescaler wrap -> `gameover`=01, `seconds_left`=0.
- Restart:
  - `reset`=1 mid-RUN, and separately in DONE -> next cycle IDLE, `gameover`=00, `seconds_left`=3.
  - `start` with `reset`=1 -> stays IDLE.
  - Near max coordinates: tom=(4095,4095), jerry=(4050,4050) -> overlap detected with no wrap.
